imem_fetch_unit: RTL and testbench

Instruction-fetch sequencer that owns the 12-bit fetch PC, reads the synchronous instruction memory, and delivers {pc, insn} pairs to decode through a valid/ready handshake. It sits between the imem read port and the decode stage. It absorbs memory latency with a 2-entry buffer and supports taken-branch redirects and a halt request from the pipeline. All state updates on the rising edge of `clk`.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 59 +++++
 rtl/imem_fetch_unit.sv | 121 ++++++++++++
 tb/tb_imem_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
package fetch_pkg;

  localparam int FETCH_ADDR_W    = 12;
  localparam int FETCH_DATA_W    = 32;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam int FETCH_STAT_W    = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Saturating increment used by the statistics counters.
  function automatic logic [FETCH_STAT_W-1:0] sat_add(
    input logic [FETCH_STAT_W-1:0] a,
    input logic [1:0]              b
  );
    logic [FETCH_STAT_W:0] s;
    s = {1'b0, a} + {{(FETCH_STAT_W-1){1'b0}}, b};
    return s[FETCH_STAT_W] ? {FETCH_STAT_W{1'b1}} : s[FETCH_STAT_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, insn} FIFO between the imem response and decode.
// Push and pop may coincide even when full; flush empties it in one cycle.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_ADDR_W,
  parameter int DW = FETCH_DATA_W
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_pc,
  input  logic [DW-1:0] i_push_insn,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [1:0]    o_count,
  output logic [AW-1:0] o_head_pc,
  output logic [DW-1:0] o_head_insn
);

  logic [AW-1:0] r_pc   [FETCH_BUF_DEPTH];
  logic [DW-1:0] r_insn [FETCH_BUF_DEPTH];
  logic          r_head;
  logic [1:0]    r_count;
  logic          w_tail;

  // With two entries the tail is head+count mod 2; when full it aliases the
  // head, which is only written when that head is popped in the same cycle.
  assign w_tail = r_head ^ r_count[0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_insn[i] <= '0;
      end
    end else if (i_push && !i_flush) begin
      r_pc[w_tail]   <= i_push_pc;
      r_insn[w_tail] <= i_push_insn;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      if (i_pop) r_head <= ~r_head;
    end
  end

  assign o_count     = r_count;
  assign o_head_pc   = r_pc[r_head];
  assign o_head_insn = r_insn[r_head];

endmodule

// File: rtl/imem_fetch_unit.sv
// Fetch sequencer: owns the fetch PC, issues imem reads and hands {pc, insn}
// to decode. Define FETCH_STATS_EN to add the fetched/squashed counters.
module imem_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_ren,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_insn
`ifdef FETCH_STATS_EN
  ,
  output logic [FETCH_STAT_W-1:0] stat_fetched,
  output logic [FETCH_STAT_W-1:0] stat_squashed
`endif
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_infl_pc;
  logic              r_infl;
  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;

  // Occupancy after this cycle's pop: a new read may issue only if the
  // buffer is guaranteed a free slot when its data returns.
  assign w_occ   = {1'b0, w_count} + {2'b0, r_infl} - {2'b0, w_pop};
  assign w_issue = (r_state == RUN) && !halt && !redirect_valid && (w_occ < 3'd2);

  assign out_valid = (w_count != 2'd0) && !redirect_valid;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_infl && !redirect_valid;
  assign imem_ren  = w_issue;
  assign imem_addr = r_fetch_pc;

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = RUN;
    end else begin
      case (r_state)
        BOOT:    w_state_next = RUN;
        RUN:     if (halt) w_state_next = HALT;
        HALT:    w_state_next = HALT;
        default: w_state_next = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_infl     <= 1'b0;
      r_infl_pc  <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_infl  <= w_issue;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;
        r_infl_pc  <= r_fetch_pc;
      end
    end
  end

  fetch_buf #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_buf (
    .clk         (clk),
    .clr_n       (clr_n),
    .i_push      (w_push),
    .i_push_pc   (r_infl_pc),
    .i_push_insn (imem_rdata),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head_pc   (out_pc),
    .o_head_insn (out_insn)
  );

`ifdef FETCH_STATS_EN
  logic [FETCH_STAT_W-1:0] r_stat_fetched;
  logic [FETCH_STAT_W-1:0] r_stat_squashed;
  logic [1:0]              w_squash_n;

  // A redirect discards the buffered entries plus any response arriving now.
  assign w_squash_n = redirect_valid ? (w_count + {1'b0, r_infl}) : 2'd0;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_stat_fetched  <= '0;
      r_stat_squashed <= '0;
    end else begin
      r_stat_fetched  <= sat_add(r_stat_fetched, {1'b0, w_push});
      r_stat_squashed <= sat_add(r_stat_squashed, w_squash_n);
    end
  end

  assign stat_fetched  = r_stat_fetched;
  assign stat_squashed = r_stat_squashed;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed table-driven bench for imem_fetch_unit; stats checks are active
// when FETCH_STATS_EN is defined.
module tb_imem_fetch_unit;

  logic        clk;
  logic        clr_n;
  logic [11:0] imem_addr;
  logic        imem_ren;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_pc;
  logic [31:0] out_insn;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_squashed;
`endif

  int checks = 0;
  int errors = 0;

  imem_fetch_unit dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .imem_addr      (imem_addr),
    .imem_ren       (imem_ren),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_insn       (out_insn)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_squashed  (stat_squashed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: mem[a] = 0x1000_0000 + a, valid only one cycle after the read.
  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= 32'h1000_0000 + {20'd0, imem_addr};
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (clr_n && dut.w_count > 2'd2) begin
      errors++;
      $display("FAIL count_bound: count=%0d required<=2", dut.w_count);
    end
  end

  typedef struct {
    logic        clr;
    logic        rdy;
    logic        hlt;
    logic        rv;
    logic [11:0] rpc;
    logic        ev;
    logic [11:0] epc;
    logic        er;
    logic [11:0] ea;
    int          sq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic r, input logic h, input logic rv,
                     input logic [11:0] rpc, input logic ev, input logic [11:0] epc,
                     input logic er, input logic [11:0] ea, input int sq);
    vec_t v;
    v.clr = c; v.rdy = r; v.hlt = h; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.er = er; v.ea = ea; v.sq = sq;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h required %h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    logic [15:0] sq_before;
    clr_n = 1'b0; out_ready = 1'b1; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 12'h000;
    sq_before = 16'd0;

    // clr rdy hlt rv rpc | ev epc er ea | squash delta
    add(0,1,0,0,12'h000, 0,12'h000,0,12'h000, 0);
    add(0,1,0,0,12'h000, 0,12'h000,0,12'h000, 0);
    add(1,1,0,0,12'h000, 0,12'h000,0,12'h000, 0); // BOOT
    add(1,1,0,0,12'h000, 0,12'h000,1,12'h000, 0);
    add(1,1,0,0,12'h000, 0,12'h000,1,12'h001, 0);
    add(1,1,0,0,12'h000, 1,12'h000,1,12'h002, 0);
    add(1,1,0,0,12'h000, 1,12'h001,1,12'h003, 0);
    add(1,1,0,0,12'h000, 1,12'h002,1,12'h004, 0);
    for (int i = 0; i < 5; i++) add(1,0,0,0,12'h000, 1,12'h003,0,12'h005, 0);
    add(1,1,0,0,12'h000, 1,12'h003,1,12'h005, 0);
    add(1,1,0,0,12'h000, 1,12'h004,1,12'h006, 0);
    add(1,1,0,0,12'h000, 1,12'h005,1,12'h007, 0);
    add(1,1,0,0,12'h000, 1,12'h006,1,12'h008, 0);
    add(1,1,0,1,12'h7F0, 0,12'h000,0,12'h009, 2); // redirect: 1 buffered + 1 in flight
    add(1,1,0,0,12'h000, 0,12'h000,1,12'h7F0, 0);
    add(1,1,0,0,12'h000, 0,12'h000,1,12'h7F1, 0);
    add(1,1,0,0,12'h000, 1,12'h7F0,1,12'h7F2, 0);
    add(1,1,0,0,12'h000, 1,12'h7F1,1,12'h7F3, 0);
    add(1,1,0,1,12'hFFE, 0,12'h000,0,12'h7F4, 2);
    add(1,1,0,0,12'h000, 0,12'h000,1,12'hFFE, 0);
    add(1,1,0,0,12'h000, 0,12'h000,1,12'hFFF, 0);
    add(1,1,0,0,12'h000, 1,12'hFFE,1,12'h000, 0);
    add(1,1,0,0,12'h000, 1,12'hFFF,1,12'h001, 0);
    add(1,1,0,0,12'h000, 1,12'h000,1,12'h002, 0);
    add(1,1,0,0,12'h000, 1,12'h001,1,12'h003, 0);
    add(1,1,1,0,12'h000, 1,12'h002,0,12'h004, 0); // halt
    add(1,1,0,0,12'h000, 1,12'h003,0,12'h004, 0);
    add(1,1,0,0,12'h000, 0,12'h000,0,12'h004, 0);
    add(1,1,0,0,12'h000, 0,12'h000,0,12'h004, 0);
    add(1,1,0,1,12'h020, 0,12'h000,0,12'h004, 0);
    add(1,1,0,0,12'h000, 0,12'h000,1,12'h020, 0);
    add(1,1,0,0,12'h000, 0,12'h000,1,12'h021, 0);
    add(1,1,0,0,12'h000, 1,12'h020,1,12'h022, 0);
    add(1,1,0,0,12'h000, 1,12'h021,1,12'h023, 0);
    add(1,0,0,0,12'h000, 1,12'h022,0,12'h024, 0);
    add(1,0,0,0,12'h000, 1,12'h022,0,12'h024, 0);
    add(0,1,0,0,12'h000, 0,12'h000,0,12'h000, 0); // async clear, buffer full
    add(1,1,0,0,12'h000, 0,12'h000,0,12'h000, 0);
    add(1,1,0,0,12'h000, 0,12'h000,1,12'h000, 0);
    add(1,1,0,0,12'h000, 0,12'h000,1,12'h001, 0);
    add(1,1,0,0,12'h000, 1,12'h000,1,12'h002, 0);
    add(1,1,0,0,12'h000, 1,12'h001,1,12'h003, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      v = vecs[i];
      clr_n = v.clr; out_ready = v.rdy; halt = v.hlt;
      redirect_valid = v.rv; redirect_pc = v.rpc;
`ifdef FETCH_STATS_EN
      sq_before = stat_squashed;
`endif
      #2;
      $display("step %0d: valid=%b pc=%h insn=%h ren=%b addr=%h", i, out_valid, out_pc, out_insn, imem_ren, imem_addr);
      chk("out_valid", i, 32'(out_valid), 32'(v.ev));
      chk("imem_ren",  i, 32'(imem_ren),  32'(v.er));
      chk("imem_addr", i, 32'(imem_addr), 32'(v.ea));
      if (v.ev) begin
        chk("out_pc",   i, 32'(out_pc), 32'(v.epc));
        chk("out_insn", i, out_insn, 32'h1000_0000 + {20'd0, v.epc});
      end
      if (!v.clr) begin
        chk("reset_out_pc",   i, 32'(out_pc), 32'd0);
        chk("reset_out_insn", i, out_insn,    32'd0);
`ifdef FETCH_STATS_EN
        chk("reset_stat_fetched", i, 32'(stat_fetched), 32'd0);
`endif
      end
`ifdef FETCH_STATS_EN
      if (v.rv) begin
        @(posedge clk); #1;
        chk("stat_squashed", i, 32'(stat_squashed), 32'(sq_before) + 32'(v.sq));
      end
`endif
    end

    // Redirect during BOOT: honoured, fetch resumes at the new PC.
    @(negedge clk); clr_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); clr_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h100;
    #2; $display("boot redirect: ren=%b valid=%b", imem_ren, out_valid);
    chk("boot_rd_ren", 100, 32'(imem_ren), 32'd0);
    chk("boot_rd_valid", 100, 32'(out_valid), 32'd0);
    @(negedge clk); redirect_valid = 1'b0;
    #2; $display("boot redirect +1: ren=%b addr=%h", imem_ren, imem_addr);
    chk("boot_rd_ren1", 101, 32'(imem_ren), 32'd1);
    chk("boot_rd_addr1", 101, 32'(imem_addr), 32'h100);
    @(negedge clk);
    #2; chk("boot_rd_addr2", 102, 32'(imem_addr), 32'h101);
    @(negedge clk);
    #2; $display("boot redirect +3: valid=%b pc=%h insn=%h", out_valid, out_pc, out_insn);
    chk("boot_rd_valid3", 103, 32'(out_valid), 32'd1);
    chk("boot_rd_pc3", 103, 32'(out_pc), 32'h100);
    chk("boot_rd_insn3", 103, out_insn, 32'h1000_0100);
`ifdef FETCH_STATS_EN
    chk("boot_rd_fetched", 103, 32'(stat_fetched), 32'd1);
    chk("boot_rd_squashed", 103, 32'(stat_squashed), 32'd0);
`endif

    // Redirect and halt together: redirect wins, fetching continues.
    @(negedge clk); halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h200;
    #2; chk("prio_valid", 110, 32'(out_valid), 32'd0);
    chk("prio_ren", 110, 32'(imem_ren), 32'd0);
    @(negedge clk); halt = 1'b0; redirect_valid = 1'b0;
    #2; $display("priority +1: ren=%b addr=%h", imem_ren, imem_addr);
    chk("prio_ren1", 111, 32'(imem_ren), 32'd1);
    chk("prio_addr1", 111, 32'(imem_addr), 32'h200);
    @(negedge clk);
    #2; chk("prio_ren2", 112, 32'(imem_ren), 32'd1);
    chk("prio_addr2", 112, 32'(imem_addr), 32'h201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
